// File: rtl/vga_pkg.sv
// Shared timing defaults, marker bundle and helpers for the VGA raster generator.
// Defaults describe 640x480@60 (800x525 totals).
package vga_pkg;

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int MAX_CW        = 16;
  localparam int PX_W          = 3 * MAX_CW;
  localparam int MAX_FETCH_LAT = 4;

  typedef enum int {
    CH_R = 0,
    CH_G = 1,
    CH_B = 2
  } ch_e;

  // Timing signals that travel together down the alignment pipeline.
  typedef struct packed {
    logic fs;
    logic ls;
    logic de;
    logic vs;
    logic hs;
  } sync_t;

  // Never returns less than 1 so a degenerate size still yields a legal port.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Pixel words are {B,G,R} with R in the LSBs; cw is the channel width.
  function automatic logic [MAX_CW-1:0] px_field(input logic [PX_W-1:0] px,
                                                 input int cw,
                                                 input ch_e ch);
    logic [PX_W-1:0] mask;
    mask = (PX_W'(1) << cw) - PX_W'(1);
    return MAX_CW'((px >> (int'(ch) * cw)) & mask);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register, W bits by D stages, async reset to RST_VAL.
// Latency D enabled cycles; contents hold while en is low.
module vga_delay_line #(
  parameter int           W       = 1,
  parameter int           D       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) sr[i] <= RST_VAL;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];

  if (D < 1) begin : g_bad_depth
    $error("vga_delay_line: depth must be at least 1");
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator and pixel fetcher; every output lags the counters by FETCH_LAT+2 enabled cycles.
// No backpressure: en low freezes counters, pipeline and outputs (markers included).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACT     = DEF_H_ACT,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACT     = DEF_V_ACT,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = 4,
  parameter int FETCH_LAT = 1,
  parameter int FC_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [3*CW-1:0]         din,
  output logic [clog2(V_ACT)-1:0] row,
  output logic [clog2(H_ACT)-1:0] col,
  output logic                    rdn,
  output logic [CW-1:0]           r,
  output logic [CW-1:0]           g,
  output logic [CW-1:0]           b,
  output logic                    hs,
  output logic                    vs,
  output logic                    de,
  output logic                    line_start,
  output logic                    frame_start,
  output logic [FC_W-1:0]         frame_cnt
);

  localparam int H_TOT  = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT  = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_ACT0 = H_SYNC + H_BP;
  localparam int V_ACT0 = V_SYNC + V_BP;
  // One spare bit of headroom so every region bound up to the total fits.
  localparam int HW     = clog2(H_TOT + 1);
  localparam int VW     = clog2(V_TOT + 1);
  localparam int RW     = clog2(V_ACT);
  localparam int CLW    = clog2(H_ACT);
  localparam int PIPE_D = FETCH_LAT + 1;

  localparam sync_t SYNC_BLANK = '{fs: 1'b0, ls: 1'b0, de: 1'b0,
                                   vs: ~VS_POL, hs: ~HS_POL};

  if (FETCH_LAT < 0 || FETCH_LAT > MAX_FETCH_LAT) begin : g_bad_lat
    $error("vga_timing_gen: FETCH_LAT must be in 0..4");
  end
  if (CW < 1 || CW > MAX_CW) begin : g_bad_cw
    $error("vga_timing_gen: CW must be in 1..16");
  end
  if (H_ACT < 1 || V_ACT < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_geom
    $error("vga_timing_gen: active and sync sizes must be non-zero");
  end

  // ---------------------------------------------------------------- stage 0
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == HW'(H_TOT - 1));
  assign v_last = (v_cnt == VW'(V_TOT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt     <= '0;
          frame_cnt <= frame_cnt + FC_W'(1);
        end else begin
          v_cnt <= v_cnt + VW'(1);
        end
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  logic  h_vis;
  logic  v_vis;
  sync_t s0;

  always_comb begin
    h_vis = (h_cnt >= HW'(H_ACT0)) && (h_cnt < HW'(H_ACT0 + H_ACT));
    v_vis = (v_cnt >= VW'(V_ACT0)) && (v_cnt < VW'(V_ACT0 + V_ACT));
    s0.hs = (h_cnt < HW'(H_SYNC)) ? HS_POL : ~HS_POL;
    s0.vs = (v_cnt < VW'(V_SYNC)) ? VS_POL : ~VS_POL;
    s0.de = h_vis && v_vis;
    s0.ls = (h_cnt == '0);
    s0.fs = (h_cnt == '0) && (v_cnt == '0);
  end

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
      rdn <= 1'b1;
    end else if (en) begin
      rdn <= ~s0.de;
      row <= s0.de ? RW'(v_cnt - VW'(V_ACT0)) : '0;
      col <= s0.de ? CLW'(h_cnt - HW'(H_ACT0)) : '0;
    end
  end

  // Timing signals wait here for the memory read launched from stage 1.
  sync_t s_dly;

  vga_delay_line #(
    .W      ($bits(sync_t)),
    .D      (PIPE_D),
    .RST_VAL(SYNC_BLANK)
  ) u_sync_dly (
    .clk(clk),
    .rst(rst),
    .en (en),
    .d  (s0),
    .q  (s_dly)
  );

  // ----------------------------------------------------------- output stage
  logic [PX_W-1:0] px;

  assign px = PX_W'(din);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else if (en) begin
      hs          <= s_dly.hs;
      vs          <= s_dly.vs;
      de          <= s_dly.de;
      line_start  <= s_dly.ls;
      frame_start <= s_dly.fs;
      r           <= s_dly.de ? CW'(px_field(px, CW, CH_R)) : '0;
      g           <= s_dly.de ? CW'(px_field(px, CW, CH_G)) : '0;
      b           <= s_dly.de ? CW'(px_field(px, CW, CH_B)) : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (29x11 totals, FETCH_LAT=2, FC_W=2),
// checked each cycle against a raster-position model plus hand-computed event positions.
module tb_vga_timing_gen;

  localparam int H_ACT = 20, H_FP = 2, H_SYNC = 3, H_BP = 4;
  localparam int V_ACT = 6,  V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;
  localparam int CW = 4, FL = 2, FC_W = 2;
  localparam int HT = 29, VT = 11, FT = HT * VT, L = FL + 2;
  localparam int HA0 = H_SYNC + H_BP, VA0 = V_SYNC + V_BP;
  localparam int HIST = 4096;
  localparam int MID_K = 5 * FT + 160;  // v=5, h=15 of the sixth frame

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [3*CW-1:0]   din = '0;
  logic [2:0]        row;
  logic [4:0]        col;
  logic              rdn;
  logic [CW-1:0]     r, g, b;
  logic              hs, vs, de, line_start, frame_start;
  logic [FC_W-1:0]   frame_cnt;

  int checks = 0;
  int failures = 0;
  int k = 0;            // enabled edges since reset release: the model's only state
  bit chk_on = 1'b0;
  int seg = 0;
  bit stalled = 1'b0, seen_fs = 1'b0, seen_de = 1'b0;
  int n_hs = 0, n_vs = 0, n_de = 0, n_ls = 0, n_fs = 0, n_rdn = 0, fs_total = 0;
  int fc_seq [5] = '{1, 2, 3, 0, 1};

  logic       hist_rdn [HIST];
  logic [2:0] hist_row [HIST];
  logic [4:0] hist_col [HIST];

  vga_timing_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .FETCH_LAT(FL), .FC_W(FC_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .row(row), .col(col), .rdn(rdn),
    .r(r), .g(g), .b(b),
    .hs(hs), .vs(vs), .de(de),
    .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", nm, act, exp, k);
    end
  endtask

  function automatic int h_of(input int p);
    return p % HT;
  endfunction

  function automatic int v_of(input int p);
    return (p / HT) % VT;
  endfunction

  function automatic bit vis(input int p);
    return h_of(p) >= HA0 && h_of(p) < HA0 + H_ACT &&
           v_of(p) >= VA0 && v_of(p) < VA0 + V_ACT;
  endfunction

  // Framebuffer contents: {B,G,R} = {col[3:0], row[3:0], col[7:4]}.
  function automatic logic [11:0] mem(input int rr, input int cc);
    logic [7:0] r8, c8;
    r8 = 8'(rr);
    c8 = 8'(cc);
    return {c8[3:0], r8[3:0], c8[7:4]};
  endfunction

  // Outputs at state k show raster position k-L; the address port shows k-1.
  always @(negedge clk) begin : cmp
    int q;
    logic e_rdn, e_hs, e_vs, e_de, e_ls, e_fs;
    int e_row, e_col;
    logic [11:0] e_px;
    if (chk_on) begin
      e_rdn = 1'b1; e_row = 0; e_col = 0;
      if (k >= 1 && vis(k - 1)) begin
        e_rdn = 1'b0;
        e_row = v_of(k - 1) - VA0;
        e_col = h_of(k - 1) - HA0;
      end
      e_hs = ~HS_POL; e_vs = ~VS_POL; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_px = '0;
      if (k >= L) begin
        q    = k - L;
        e_hs = (h_of(q) < H_SYNC) ? HS_POL : ~HS_POL;
        e_vs = (v_of(q) < V_SYNC) ? VS_POL : ~VS_POL;
        e_de = vis(q);
        e_ls = (h_of(q) == 0);
        e_fs = (h_of(q) == 0) && (v_of(q) == 0);
        if (e_de) e_px = mem(v_of(q) - VA0, h_of(q) - HA0);
      end
      chk("rdn", 32'(rdn), 32'(e_rdn));
      chk("row", 32'(row), 32'(e_row));
      chk("col", 32'(col), 32'(e_col));
      chk("hs", 32'(hs), 32'(e_hs));
      chk("vs", 32'(vs), 32'(e_vs));
      chk("de", 32'(de), 32'(e_de));
      chk("line_start", 32'(line_start), 32'(e_ls));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("r", 32'(r), 32'(e_px[3:0]));
      chk("g", 32'(g), 32'(e_px[7:4]));
      chk("b", 32'(b), 32'(e_px[11:8]));
      chk("frame_cnt", 32'(frame_cnt), 32'((k / FT) % 4));
    end
  end

  task automatic measure();
    if (seg == 0 && k >= L && k < L + FT) begin
      if (hs == 1'b0) n_hs++;
      if (vs == 1'b1) n_vs++;
      if (de) n_de++;
      if (line_start) n_ls++;
      if (frame_start) n_fs++;
    end
    if (seg == 0 && k >= 1 && k < 1 + FT && !rdn) n_rdn++;
    if (seg == 0 && k <= 5 * FT && frame_start) fs_total++;
    if (!seen_fs && frame_start) begin
      seen_fs = 1'b1;
      chk("first_frame_start_k", 32'(k), 32'd4);
    end
    if (!seen_de && de) begin
      seen_de = 1'b1;
      chk("first_de_k", 32'(k), 32'd127);   // 4 lines*29 + 7 + L
    end
    if (seg == 0 && k % FT == 0 && k / FT >= 1 && k / FT <= 5)
      chk("frame_cnt_wrap", 32'(frame_cnt), 32'(fc_seq[k / FT - 1]));
  endtask

  // One clock: drive en, let the edge happen, then play the memory for the next edge.
  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    if (rst && e) k++;
    #1;
    if (k < HIST) begin
      hist_rdn[k] = rdn;
      hist_row[k] = row;
      hist_col[k] = col;
    end
    if (k >= FL && k < HIST && !hist_rdn[k - FL])
      din = mem(int'(hist_row[k - FL]), int'(hist_col[k - FL]));
    else
      din = 12'($urandom);
    if (rst && e) measure();
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_hs"}, 32'(hs), 32'd1);
    chk({tag, "_vs"}, 32'(vs), 32'd0);
    chk({tag, "_rdn"}, 32'(rdn), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_row"}, 32'(row), 32'd0);
    chk({tag, "_col"}, 32'(col), 32'd0);
    chk({tag, "_rgb"}, 32'({b, g, r}), 32'd0);
    chk({tag, "_ls"}, 32'(line_start), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_fc"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    int iter;
    #1 rst = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) step(1'b1);
    chk_blank("reset");
    rst = 1'b1;

    iter = 0;
    while (k < MID_K && iter < 20000) begin
      iter++;
      if (k == 505 && !stalled) begin
        stalled = 1'b1;                 // mid-line, visible pixels in flight
        repeat (5) step(1'b0);
      end
      if (k >= 3 * FT && k < 4 * FT) step($urandom_range(0, 3) != 0);
      else step(1'b1);
    end
    if (k != MID_K) chk("reach_mid_reset_point", 32'(k), 32'(MID_K));

    chk("hs_active_cycles_per_frame", 32'(n_hs), 32'd33);
    chk("vs_active_cycles_per_frame", 32'(n_vs), 32'd58);
    chk("de_cycles_per_frame", 32'(n_de), 32'd120);
    chk("line_start_per_frame", 32'(n_ls), 32'd11);
    chk("frame_start_per_frame", 32'(n_fs), 32'd1);
    chk("rdn_low_per_frame", 32'(n_rdn), 32'd120);
    chk("frame_start_in_5_frames", 32'(fs_total), 32'd5);

    // Raster position 1751 is visible, so the blanking below is observable.
    chk("pre_reset_de", 32'(de), 32'd1);
    chk("pre_reset_rdn", 32'(rdn), 32'd0);
    #2 rst = 1'b0;
    k = 0;
    #1 chk_blank("async_reset");
    repeat (2) step(1'b1);
    rst = 1'b1;
    seg = 1;
    seen_fs = 1'b0;
    seen_de = 1'b0;
    repeat (2 * FT) step(1'b1);
    chk("restart_seen_frame_start", 32'(seen_fs), 32'd1);
    chk("restart_seen_de", 32'(seen_de), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster generator and pixel fetcher; next generation of the fixed 640x480 scan controller.
- Generates H/V counters, sync, data-enable and frame/line markers, and issues pixel-memory read addresses.
- Compensates a configurable memory read latency so RGB, sync and DE leave the block aligned.
- Sits between the display framebuffer (board renderer) and the VGA connector pins.

Parameters:
- H_ACT, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACT, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs
- CW, 4, bits per colour channel
- FETCH_LAT, 1, cycles from row/col/rdn output to valid din (range 0..4)
- FC_W, 8, frame counter width

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  pixel clock enable; all state advances only when high
- din  in  3*CW  pixel data {B,G,R}, R in LSBs
- row  out  clog2(V_ACT)  framebuffer row address
- col  out  clog2(H_ACT)  framebuffer column address
- rdn  out  1  active-low read request
- r, g, b  out  CW each  colour outputs
- hs, vs  out  1  sync outputs
- de  out  1  visible-pixel data enable
- line_start  out  1  one-cycle marker, first cycle of each line
- frame_start  out  1  one-cycle marker, first cycle of each frame
- frame_cnt  out  FC_W  completed-frame count

Behaviour:
- Totals: H_TOT = H_SYNC+H_BP+H_ACT+H_FP and V_TOT = V_SYNC+V_BP+V_ACT+V_FP; defaults give 800 and 525.
- Line order is sync, back porch, active, front porch.
- Stage 0 counters: h_cnt 0..H_TOT-1, advances on en.
  - At H_TOT-1, h_cnt wraps to 0 and v_cnt advances.
  - v_cnt wraps to 0 after V_TOT-1.
  - frame_cnt increments (mod 2^FC_W) on the same edge as the v_cnt wrap.
- Active region is h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT); defaults are h 144..783 and v 35..514.
- Stage 1 is registered from stage 0:
  - col = h_cnt-(H_SYNC+H_BP) and row = v_cnt-(V_SYNC+V_BP), truncated to port width.
  - row/col hold 0 outside the active region.
  - rdn = ~active.
- din is sampled FETCH_LAT enabled cycles after the matching stage-1 address.
- Output stage: hs, vs, de, line_start and frame_start are delayed so that all outputs lag stage 0 by exactly L = FETCH_LAT+2 enabled cycles.
  - r/g/b = de-aligned ? din fields : 0.
- Sync levels:
  - hs = HS_POL while h_cnt < H_SYNC, else ~HS_POL.
  - vs = VS_POL while v_cnt < V_SYNC, else ~VS_POL.
  - Both are evaluated at stage 0, then delayed.
- line_start is stage-0 h_cnt==0; frame_start is stage-0 h_cnt==0 && v_cnt==0. Both are delayed by L and are high for one enabled cycle.
- en low: counters, pipeline and all outputs hold their values. Markers stay high if they were high, so consumers must qualify markers with en.
- Reset (rst low, asynchronous):
  - Counters are 0; row and col are 0; rdn is 1.
  - r/g/b are 0; de is 0; line_start and frame_start are 0; frame_cnt is 0.
  - hs = ~HS_POL and vs = ~VS_POL.
  - Every pipeline register is loaded with these blank values.
- Reset mid-frame: all outputs go to the blank state immediately. The first cycle after release restarts at (0,0), and frame_start appears L cycles later.
- FETCH_LAT outside 0..4 is an elaboration error.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing constants
  - a clog2 function
  - a pixel-field slicing helper for {B,G,R}
- Sub-module vga_delay_line: parametrised width/depth shift register with enable and async active-low reset to a per-bit reset value. It is used for the hs/vs/de/marker pipeline.

Test Plan:
- Reset values: hold rst low, toggle clk -> outputs match the reset list above; with default polarities hs=1, vs=1, rdn=1.
- Sync timing (defaults, en=1): measure hs -> low for exactly 96 cycles of every 800; vs low for exactly 2 lines of 525; rdn low for 640 cycles per visible line.
- Alignment with FETCH_LAT=2: drive a memory model returning din = {col[3:0], row[3:0], col[7:4]} after 2 cycles -> every de=1 cycle carries the correct pixel; r/g/b=0 when de=0; first de at frame_start + 35 lines + 144 cycles.
- Enable stall: small config (H_ACT=8, V_ACT=4, porches=1, syncs=2); drop en for 5 cycles mid-line -> every output frozen, then resumes with no skipped or duplicated pixel.
- Frame wrap with FC_W=2: run 5 frames -> frame_cnt sequence 1,2,3,0,1, with exactly one frame_start per frame.
- Reset mid-line: assert rst at v=100, h=400 -> outputs blank asynchronously; after release the first frame_start arrives L cycles later and timing matches the reset-start reference.
